// File: rtl/reg_hazard_scoreboard_pkg.sv
`default_nettype none
// ============================================================================
// Module   : reg_hazard_scoreboard_pkg
// Brief    : Opcode map, load class and latency defaults for the ID scoreboard
// Revision : 1.0 - initial release
// ============================================================================
package reg_hazard_scoreboard_pkg;

  localparam int INST_OP_W = 6;
  typedef logic [INST_OP_W-1:0] inst_op_t;

  localparam inst_op_t c_OP_SPECIAL = 6'h00;
  localparam inst_op_t c_OP_REGIMM  = 6'h01;  // BLTZ
  localparam inst_op_t c_OP_J       = 6'h02;
  localparam inst_op_t c_OP_JAL     = 6'h03;
  localparam inst_op_t c_OP_BEQ     = 6'h04;
  localparam inst_op_t c_OP_BNE     = 6'h05;
  localparam inst_op_t c_OP_BLEZ    = 6'h06;
  localparam inst_op_t c_OP_BGTZ    = 6'h07;
  localparam inst_op_t c_OP_ADDIU   = 6'h09;
  localparam inst_op_t c_OP_SLTI    = 6'h0A;
  localparam inst_op_t c_OP_SLTIU   = 6'h0B;
  localparam inst_op_t c_OP_ANDI    = 6'h0C;
  localparam inst_op_t c_OP_ORI     = 6'h0D;
  localparam inst_op_t c_OP_LUI     = 6'h0F;
  localparam inst_op_t c_OP_LB      = 6'h20;
  localparam inst_op_t c_OP_LH      = 6'h21;
  localparam inst_op_t c_OP_LW      = 6'h23;
  localparam inst_op_t c_OP_LBU     = 6'h24;
  localparam inst_op_t c_OP_LHU     = 6'h25;
  localparam inst_op_t c_OP_SB      = 6'h28;
  localparam inst_op_t c_OP_SH      = 6'h29;
  localparam inst_op_t c_OP_SW      = 6'h2B;

  localparam int c_ALU_LAT_DEF   = 0;
  localparam int c_LOAD_LAT_DEF  = 1;
  localparam int c_NOFWD_LAT_DEF = 3;

  typedef enum logic [1:0] {RD_NONE, RD_ONE, RD_TWO} rd_class_e;
  typedef enum logic [1:0] {WR_NONE, WR_RT, WR_RD, WR_R31} wr_class_e;

  function automatic logic is_load_op(input inst_op_t op);
    return (op == c_OP_LB) || (op == c_OP_LBU) || (op == c_OP_LH) ||
           (op == c_OP_LHU) || (op == c_OP_LW);
  endfunction

  function automatic int cnt_width(input int max_lat);
    int w;
    w = $clog2(max_lat + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage
`default_nettype wire

// File: rtl/reg_field_decode.sv
`default_nettype none
// ============================================================================
// Module   : reg_field_decode
// Brief    : Opcode to register-file read/write enables and addresses
// Revision : 1.0 - initial release
// ============================================================================
module reg_field_decode
  import reg_hazard_scoreboard_pkg::*;
#(
  parameter int ADDR_W = 5
) (
  input  logic [INST_OP_W-1:0] i_op,
  input  logic [ADDR_W-1:0]    i_rs,
  input  logic [ADDR_W-1:0]    i_rt,
  input  logic [ADDR_W-1:0]    i_rd,
  output logic                 o_reg_read_en_1,
  output logic                 o_reg_read_en_2,
  output logic [ADDR_W-1:0]    o_reg_addr_1,
  output logic [ADDR_W-1:0]    o_reg_addr_2,
  output logic                 o_reg_write_en,
  output logic [ADDR_W-1:0]    o_reg_write_addr,
  output logic                 o_is_load
);

  rd_class_e w_rd_cls;
  wr_class_e w_wr_cls;

  always_comb begin
    w_rd_cls = RD_NONE;
    case (i_op)
      c_OP_BGTZ, c_OP_REGIMM, c_OP_ADDIU, c_OP_ORI, c_OP_SLTI, c_OP_SLTIU,
      c_OP_LB, c_OP_LW, c_OP_LBU, c_OP_LH, c_OP_LHU:
        w_rd_cls = RD_ONE;
      c_OP_BEQ, c_OP_BNE, c_OP_ANDI, c_OP_SB, c_OP_SW, c_OP_SH, c_OP_SPECIAL:
        w_rd_cls = RD_TWO;
      default:
        w_rd_cls = RD_NONE;
    endcase
  end

  always_comb begin
    w_wr_cls = WR_NONE;
    case (i_op)
      c_OP_ADDIU, c_OP_LUI, c_OP_SLTI, c_OP_SLTIU, c_OP_ANDI, c_OP_ORI,
      c_OP_LB, c_OP_LW, c_OP_LBU, c_OP_LH, c_OP_LHU:
        w_wr_cls = WR_RT;
      c_OP_SPECIAL: w_wr_cls = WR_RD;
      c_OP_JAL:     w_wr_cls = WR_R31;
      default:      w_wr_cls = WR_NONE;
    endcase
  end

  // Disabled ports drive address 0 so the register file sees the zero register
  assign o_reg_read_en_1 = (w_rd_cls != RD_NONE);
  assign o_reg_read_en_2 = (w_rd_cls == RD_TWO);
  assign o_reg_addr_1    = o_reg_read_en_1 ? i_rs : '0;
  assign o_reg_addr_2    = o_reg_read_en_2 ? i_rt : '0;
  assign o_reg_write_en  = (w_wr_cls != WR_NONE);

  always_comb begin
    o_reg_write_addr = '0;
    case (w_wr_cls)
      WR_RT:   o_reg_write_addr = i_rt;
      WR_RD:   o_reg_write_addr = i_rd;
      WR_R31:  o_reg_write_addr = ADDR_W'(31);
      default: o_reg_write_addr = '0;
    endcase
  end

  assign o_is_load = is_load_op(i_op);

endmodule
`default_nettype wire

// File: rtl/reg_hazard_scoreboard.sv
`default_nettype none
// ============================================================================
// Module   : reg_hazard_scoreboard
// Brief    : ID-stage register decode with per-register busy countdown and stall
// Revision : 1.0 - initial release
// ============================================================================
module reg_hazard_scoreboard
  import reg_hazard_scoreboard_pkg::*;
#(
  parameter int REG_NUM    = 32,
  parameter int ADDR_W     = 5,
  parameter int FORWARD_EN = 1,
  parameter int ALU_LAT    = c_ALU_LAT_DEF,
  parameter int LOAD_LAT   = c_LOAD_LAT_DEF,
  parameter int NOFWD_LAT  = c_NOFWD_LAT_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_id_valid,
  input  logic [INST_OP_W-1:0] i_op,
  input  logic [ADDR_W-1:0]    i_rs,
  input  logic [ADDR_W-1:0]    i_rt,
  input  logic [ADDR_W-1:0]    i_rd,
  input  logic                 i_freeze,
  input  logic                 i_flush,
  output logic                 o_reg_read_en_1,
  output logic                 o_reg_read_en_2,
  output logic [ADDR_W-1:0]    o_reg_addr_1,
  output logic [ADDR_W-1:0]    o_reg_addr_2,
  output logic                 o_reg_write_en,
  output logic [ADDR_W-1:0]    o_reg_write_addr,
  output logic                 o_stall_req,
  output logic [REG_NUM-1:0]   o_busy_mask
);

  localparam int c_MAX_LAT = (FORWARD_EN != 0) ?
                             ((ALU_LAT > LOAD_LAT) ? ALU_LAT : LOAD_LAT) : NOFWD_LAT;
  localparam int CNT_W     = cnt_width(c_MAX_LAT);

  logic                 w_is_load;
  logic [CNT_W-1:0]     w_lat;
  logic [CNT_W-1:0]     r_cnt     [REG_NUM];
  logic [CNT_W-1:0]     w_cnt_nxt [REG_NUM];
  logic [2**ADDR_W-1:0] w_busy_ext;
  logic                 w_hz1;
  logic                 w_hz2;
  logic                 w_hazard;
  logic                 w_issue;

  reg_field_decode #(.ADDR_W(ADDR_W)) u_decode (
    .i_op             (i_op),
    .i_rs             (i_rs),
    .i_rt             (i_rt),
    .i_rd             (i_rd),
    .o_reg_read_en_1  (o_reg_read_en_1),
    .o_reg_read_en_2  (o_reg_read_en_2),
    .o_reg_addr_1     (o_reg_addr_1),
    .o_reg_addr_2     (o_reg_addr_2),
    .o_reg_write_en   (o_reg_write_en),
    .o_reg_write_addr (o_reg_write_addr),
    .o_is_load        (w_is_load)
  );

  assign w_lat = (FORWARD_EN == 0) ? CNT_W'(NOFWD_LAT) :
                 (w_is_load ? CNT_W'(LOAD_LAT) : CNT_W'(ALU_LAT));

  for (genvar gi = 0; gi < REG_NUM; gi++) begin : g_busy
    assign o_busy_mask[gi] = |r_cnt[gi];
  end

  // Widened so any address the fields can carry indexes a defined bit
  always_comb begin
    w_busy_ext                = '0;
    w_busy_ext[REG_NUM-1:0]   = o_busy_mask;
  end

  assign w_hz1    = o_reg_read_en_1 && (o_reg_addr_1 != '0) && w_busy_ext[o_reg_addr_1];
  assign w_hz2    = o_reg_read_en_2 && (o_reg_addr_2 != '0) && w_busy_ext[o_reg_addr_2];
  assign w_hazard = i_id_valid && (w_hz1 || w_hz2);
  assign o_stall_req = w_hazard && !i_flush;
  assign w_issue  = i_id_valid && !w_hazard && !i_freeze && !i_flush;

  always_comb begin
    logic [CNT_W-1:0] w_dec;
    for (int i = 0; i < REG_NUM; i++) begin
      w_cnt_nxt[i] = r_cnt[i];
      w_dec        = (r_cnt[i] != '0) ? (r_cnt[i] - CNT_W'(1)) : '0;
      if (i == 0 || i_flush) begin
        w_cnt_nxt[i] = '0;
      end else if (i_freeze) begin
        w_cnt_nxt[i] = r_cnt[i];
      end else if (w_issue && o_reg_write_en && (o_reg_write_addr == ADDR_W'(i))) begin
        // A younger, faster writer must not shorten an older, slower one
        w_cnt_nxt[i] = (w_lat > w_dec) ? w_lat : w_dec;
      end else begin
        w_cnt_nxt[i] = w_dec;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < REG_NUM; i++) r_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < REG_NUM; i++) r_cnt[i] <= w_cnt_nxt[i];
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_reg_hazard_scoreboard.sv
`default_nettype none
// ============================================================================
// Module   : tb_reg_hazard_scoreboard
// Brief    : Directed decode table plus multi-cycle scoreboard sequences
// Revision : 1.0 - initial release
// ============================================================================
module tb_reg_hazard_scoreboard;
  import reg_hazard_scoreboard_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        r_valid;
  logic [5:0]  r_op;
  logic [4:0]  r_rs, r_rt, r_rd;
  logic        r_freeze, r_flush;

  logic        w_f_re1, w_f_re2, w_f_we, w_f_stall;
  logic [4:0]  w_f_a1, w_f_a2, w_f_wa;
  logic [31:0] w_f_busy;
  logic        w_n_re1, w_n_re2, w_n_we, w_n_stall;
  logic [4:0]  w_n_a1, w_n_a2, w_n_wa;
  logic [31:0] w_n_busy;

  int checks   = 0;
  int failures = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  reg_hazard_scoreboard u_fwd (
    .clk(clk), .rst_n(rst_n), .i_id_valid(r_valid), .i_op(r_op),
    .i_rs(r_rs), .i_rt(r_rt), .i_rd(r_rd), .i_freeze(r_freeze), .i_flush(r_flush),
    .o_reg_read_en_1(w_f_re1), .o_reg_read_en_2(w_f_re2),
    .o_reg_addr_1(w_f_a1), .o_reg_addr_2(w_f_a2),
    .o_reg_write_en(w_f_we), .o_reg_write_addr(w_f_wa),
    .o_stall_req(w_f_stall), .o_busy_mask(w_f_busy)
  );

  reg_hazard_scoreboard #(.FORWARD_EN(0)) u_nfw (
    .clk(clk), .rst_n(rst_n), .i_id_valid(r_valid), .i_op(r_op),
    .i_rs(r_rs), .i_rt(r_rt), .i_rd(r_rd), .i_freeze(r_freeze), .i_flush(r_flush),
    .o_reg_read_en_1(w_n_re1), .o_reg_read_en_2(w_n_re2),
    .o_reg_addr_1(w_n_a1), .o_reg_addr_2(w_n_a2),
    .o_reg_write_en(w_n_we), .o_reg_write_addr(w_n_wa),
    .o_stall_req(w_n_stall), .o_busy_mask(w_n_busy)
  );

  typedef struct {
    logic [5:0] op;
    logic [4:0] rs, rt, rd;
    logic       re1, re2;
    logic [4:0] a1, a2;
    logic       we;
    logic [4:0] wa;
  } dec_vec_t;

  dec_vec_t vecs [13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [5:0] op, input logic [4:0] rs,
                       input logic [4:0] rt, input logic [4:0] rd,
                       input logic frz, input logic fl);
    r_valid = v; r_op = op; r_rs = rs; r_rt = rt; r_rd = rd;
    r_freeze = frz; r_flush = fl;
  endtask

  task automatic do_reset;
    drive(1'b0, c_OP_J, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  function automatic dec_vec_t mk(input logic [5:0] op, input logic [4:0] rs,
                                  input logic [4:0] rt, input logic [4:0] rd,
                                  input logic re1, input logic re2,
                                  input logic [4:0] a1, input logic [4:0] a2,
                                  input logic we, input logic [4:0] wa);
    dec_vec_t v;
    v.op = op; v.rs = rs; v.rt = rt; v.rd = rd;
    v.re1 = re1; v.re2 = re2; v.a1 = a1; v.a2 = a2; v.we = we; v.wa = wa;
    return v;
  endfunction

  initial begin
    vecs[0]  = mk(c_OP_ORI,     5'd4,  5'd5,  5'd0,  1, 0, 5'd4,  5'd0,  1, 5'd5);
    vecs[1]  = mk(c_OP_BEQ,     5'd3,  5'd4,  5'd0,  1, 1, 5'd3,  5'd4,  0, 5'd0);
    vecs[2]  = mk(c_OP_SPECIAL, 5'd6,  5'd7,  5'd8,  1, 1, 5'd6,  5'd7,  1, 5'd8);
    vecs[3]  = mk(c_OP_JAL,     5'd1,  5'd2,  5'd3,  0, 0, 5'd0,  5'd0,  1, 5'd31);
    vecs[4]  = mk(c_OP_LW,      5'd9,  5'd10, 5'd0,  1, 0, 5'd9,  5'd0,  1, 5'd10);
    vecs[5]  = mk(c_OP_SW,      5'd11, 5'd12, 5'd0,  1, 1, 5'd11, 5'd12, 0, 5'd0);
    vecs[6]  = mk(c_OP_LUI,     5'd13, 5'd14, 5'd0,  0, 0, 5'd0,  5'd0,  1, 5'd14);
    vecs[7]  = mk(c_OP_J,       5'd1,  5'd2,  5'd3,  0, 0, 5'd0,  5'd0,  0, 5'd0);
    vecs[8]  = mk(c_OP_REGIMM,  5'd15, 5'd1,  5'd0,  1, 0, 5'd15, 5'd0,  0, 5'd0);
    vecs[9]  = mk(c_OP_ANDI,    5'd16, 5'd17, 5'd0,  1, 1, 5'd16, 5'd17, 1, 5'd17);
    vecs[10] = mk(c_OP_BLEZ,    5'd18, 5'd19, 5'd0,  0, 0, 5'd0,  5'd0,  0, 5'd0);
    vecs[11] = mk(c_OP_LHU,     5'd19, 5'd20, 5'd0,  1, 0, 5'd19, 5'd0,  1, 5'd20);
    vecs[12] = mk(6'h3F,        5'd21, 5'd22, 5'd23, 0, 0, 5'd0,  5'd0,  0, 5'd0);

    // Reset asserted: counters clear, decode still follows the inputs
    rst_n = 1'b0;
    drive(1'b1, c_OP_ORI, 5'd4, 5'd5, 5'd0, 1'b0, 1'b0);
    #3;
    chk("reset_busy", w_f_busy, 32'h0);
    chk("reset_stall", {31'b0, w_f_stall}, 32'h0);
    chk("reset_decode", {26'b0, w_f_we, w_f_wa}, {26'b0, 1'b1, 5'd5});
    @(negedge clk);
    rst_n = 1'b1;

    // Decode table; flush keeps the counters idle
    for (int i = 0; i < 13; i++) begin
      drive(1'b1, vecs[i].op, vecs[i].rs, vecs[i].rt, vecs[i].rd, 1'b0, 1'b1);
      #2;
      chk($sformatf("dec_fwd[%0d]", i),
          {14'b0, w_f_re1, w_f_re2, w_f_a1, w_f_a2, w_f_we, w_f_wa},
          {14'b0, vecs[i].re1, vecs[i].re2, vecs[i].a1, vecs[i].a2, vecs[i].we, vecs[i].wa});
      chk($sformatf("dec_nfw[%0d]", i),
          {14'b0, w_n_re1, w_n_re2, w_n_a1, w_n_a2, w_n_we, w_n_wa},
          {14'b0, vecs[i].re1, vecs[i].re2, vecs[i].a1, vecs[i].a2, vecs[i].we, vecs[i].wa});
      @(negedge clk);
    end

    // Load-use: exactly one bubble with forwarding
    do_reset();
    drive(1'b1, c_OP_LW, 5'd1, 5'd8, 5'd0, 1'b0, 1'b0); #2;
    chk("lu_c0_stall", {31'b0, w_f_stall}, 32'h0);
    @(negedge clk);
    drive(1'b1, c_OP_SPECIAL, 5'd8, 5'd2, 5'd3, 1'b0, 1'b0); #2;
    chk("lu_c1_stall", {31'b0, w_f_stall}, 32'h1);
    chk("lu_c1_busy", w_f_busy, 32'h0000_0100);
    @(negedge clk); #2;
    chk("lu_c2_stall", {31'b0, w_f_stall}, 32'h0);
    chk("lu_c2_busy", w_f_busy, 32'h0);
    @(negedge clk);
    drive(1'b0, c_OP_J, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0); #2;
    chk("lu_c3_busy", w_f_busy, 32'h0);
    @(negedge clk);

    // No forwarding: ADDIU $3 then BEQ $3,$4 stalls three cycles
    do_reset();
    drive(1'b1, c_OP_ADDIU, 5'd1, 5'd3, 5'd0, 1'b0, 1'b0); #2;
    chk("nf_c0_stall", {31'b0, w_n_stall}, 32'h0);
    @(negedge clk);
    drive(1'b1, c_OP_BEQ, 5'd3, 5'd4, 5'd0, 1'b0, 1'b0);
    for (int c = 1; c <= 3; c++) begin
      #2;
      chk($sformatf("nf_c%0d_stall", c), {31'b0, w_n_stall}, 32'h1);
      chk($sformatf("nf_c%0d_busy", c), w_n_busy, 32'h0000_0008);
      @(negedge clk);
    end
    #2;
    chk("nf_c4_stall", {31'b0, w_n_stall}, 32'h0);
    chk("nf_c4_busy", w_n_busy, 32'h0);
    @(negedge clk);

    // No forwarding: WAW on $9, then LUI $0 never marks register 0
    do_reset();
    drive(1'b1, c_OP_LW, 5'd1, 5'd9, 5'd0, 1'b0, 1'b0); #2;
    chk("waw_c0_busy", w_n_busy, 32'h0);
    @(negedge clk);
    drive(1'b1, c_OP_ADDIU, 5'd1, 5'd9, 5'd0, 1'b0, 1'b0); #2;
    chk("waw_c1_busy", w_n_busy, 32'h0000_0200);
    chk("waw_c1_stall", {31'b0, w_n_stall}, 32'h0);
    @(negedge clk);
    drive(1'b1, c_OP_LUI, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0); #2;
    chk("waw_c2_busy", w_n_busy, 32'h0000_0200);
    @(negedge clk);
    drive(1'b0, c_OP_J, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    for (int c = 3; c <= 4; c++) begin
      #2;
      chk($sformatf("waw_c%0d_busy", c), w_n_busy, 32'h0000_0200);
      @(negedge clk);
    end
    #2;
    chk("waw_c5_busy", w_n_busy, 32'h0);
    @(negedge clk);

    // Freeze mid-countdown extends the load-use stall by its duration
    do_reset();
    drive(1'b1, c_OP_LW, 5'd1, 5'd8, 5'd0, 1'b0, 1'b0); #2;
    chk("frz_c0_stall", {31'b0, w_f_stall}, 32'h0);
    @(negedge clk);
    for (int c = 1; c <= 3; c++) begin
      drive(1'b1, c_OP_SPECIAL, 5'd8, 5'd2, 5'd3, (c < 3), 1'b0); #2;
      chk($sformatf("frz_c%0d_stall", c), {31'b0, w_f_stall}, 32'h1);
      chk($sformatf("frz_c%0d_busy", c), w_f_busy, 32'h0000_0100);
      @(negedge clk);
    end
    #2;
    chk("frz_c4_stall", {31'b0, w_f_stall}, 32'h0);
    chk("frz_c4_busy", w_f_busy, 32'h0);
    @(negedge clk);

    // Flush clears, flush beats a concurrent JAL, async reset mid-countdown
    do_reset();
    drive(1'b1, c_OP_ADDIU, 5'd0, 5'd8, 5'd0, 1'b0, 1'b0);
    @(negedge clk);
    drive(1'b1, c_OP_ADDIU, 5'd0, 5'd9, 5'd0, 1'b0, 1'b0); #2;
    chk("fl_c1_busy", w_n_busy, 32'h0000_0100);
    @(negedge clk);
    drive(1'b1, c_OP_SPECIAL, 5'd8, 5'd9, 5'd1, 1'b0, 1'b1); #2;
    chk("fl_c2_busy", w_n_busy, 32'h0000_0300);
    chk("fl_c2_stall", {31'b0, w_n_stall}, 32'h0);
    @(negedge clk);
    drive(1'b1, c_OP_JAL, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1); #2;
    chk("fl_c3_busy", w_n_busy, 32'h0);
    @(negedge clk);
    drive(1'b0, c_OP_J, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0); #2;
    chk("fl_jal_dropped", w_n_busy, 32'h0);
    @(negedge clk);
    drive(1'b1, c_OP_JAL, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    @(negedge clk);
    drive(1'b0, c_OP_J, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0); #2;
    chk("jal_busy31", w_n_busy, 32'h8000_0000);
    @(negedge clk); #2;
    chk("jal_busy31_c2", w_n_busy, 32'h8000_0000);
    rst_n = 1'b0;
    #1;
    chk("async_rst_busy", w_n_busy, 32'h0);
    chk("async_rst_stall", {31'b0, w_n_stall}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
